// File: rtl/gesture_pkg.sv
// rtl/gesture_pkg.sv - shared types and constants for the gesture read path
package gesture_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_POLL,
        S_REQ,
        S_WAIT_END,
        S_DECODE
`ifdef GESTURE_WAVE_EN
        ,
        S_REQ2,
        S_WAIT_END2
`endif
    } state_t;

    localparam logic [3:0] G_NONE          = 4'd0;
    localparam logic [3:0] G_UP            = 4'd1;
    localparam logic [3:0] G_DOWN          = 4'd2;
    localparam logic [3:0] G_LEFT          = 4'd3;
    localparam logic [3:0] G_RIGHT         = 4'd4;
    localparam logic [3:0] G_FORWARD       = 4'd5;
    localparam logic [3:0] G_BACKWARD      = 4'd6;
    localparam logic [3:0] G_CLOCKWISE     = 4'd7;
    localparam logic [3:0] G_ANTICLOCKWISE = 4'd8;
    localparam logic [3:0] G_WAVE          = 4'd9;

    localparam logic [7:0] ADDR_FLAG1 = 8'h43;
    localparam logic [7:0] ADDR_FLAG2 = 8'h44;

    localparam logic [2:0] STEP_ACTIVE = 3'd5;

endpackage

// File: rtl/gesture_decode.sv
// rtl/gesture_decode.sv - lowest-set-bit priority encoder for the gesture flag byte
module gesture_decode
    import gesture_pkg::*;
(
    input  logic [7:0] flag_byte,
    output logic [3:0] code,
    output logic       nz
);

    // Scan from the top bit down so the lowest set bit is the last to win.
    always_comb begin
        code = G_NONE;
        for (int i = 7; i >= 0; i--) begin
            if (flag_byte[i]) begin
                code = 4'(i + 1);
            end
        end
        nz = |flag_byte;
    end

endmodule

// File: rtl/gesture_rd_ctrl.sv
// rtl/gesture_rd_ctrl.sv - polls gesture flag register over i2c_ctrl and decodes it; optional GESTURE_WAVE_EN
module gesture_rd_ctrl
    import gesture_pkg::*;
#(
    parameter logic [15:0] POLL_CYCLES    = 16'd25000,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd4000,
    parameter logic [7:0]  FLAG_REG       = ADDR_FLAG1
) (
    input  logic       i2c_clk,
    input  logic       sys_rst_n,
    input  logic [2:0] step,
    input  logic       i2c_end,
    input  logic [7:0] rd_data,
    output logic       rd_start,
    output logic [7:0] rd_addr,
    output logic       gesture_valid,
    output logic [3:0] gesture_code,
    output logic [7:0] gesture_raw,
    output logic       rd_timeout
);

    state_t      state_q;
    state_t      state_d;
    logic [15:0] poll_cnt;
    logic [15:0] to_cnt;
    logic        active;
    logic        in_wait_end;
    logic [3:0]  dec_code;
    logic        dec_nz;

    assign active = (step == STEP_ACTIVE);

`ifdef GESTURE_WAVE_EN
    logic wave_pend;
    assign in_wait_end = (state_q == S_WAIT_END) || (state_q == S_WAIT_END2);
`else
    assign in_wait_end = (state_q == S_WAIT_END);
`endif

    gesture_decode u_decode (
        .flag_byte (gesture_raw),
        .code      (dec_code),
        .nz        (dec_nz)
    );

    // State register.
    always_ff @(posedge i2c_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic plus the one-cycle request and timeout strobes.
    always_comb begin
        state_d    = state_q;
        rd_start   = 1'b0;
        rd_timeout = 1'b0;
        if (!active) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:      state_d = S_WAIT_POLL;
                S_WAIT_POLL: begin
                    if (poll_cnt == POLL_CYCLES - 16'd1) begin
                        state_d = S_REQ;
                    end
                end
                S_REQ: begin
                    rd_start = 1'b1;
                    state_d  = S_WAIT_END;
                end
                S_WAIT_END: begin
                    if (i2c_end) begin
                        state_d = S_DECODE;
                    end else if (to_cnt == TIMEOUT_CYCLES - 16'd1) begin
                        rd_timeout = 1'b1;
                        state_d    = S_WAIT_POLL;
                    end
                end
                S_DECODE: begin
`ifdef GESTURE_WAVE_EN
                    state_d = dec_nz ? S_WAIT_POLL : S_REQ2;
`else
                    state_d = S_WAIT_POLL;
`endif
                end
`ifdef GESTURE_WAVE_EN
                S_REQ2: begin
                    rd_start = 1'b1;
                    state_d  = S_WAIT_END2;
                end
                S_WAIT_END2: begin
                    if (i2c_end) begin
                        state_d = S_WAIT_POLL;
                    end else if (to_cnt == TIMEOUT_CYCLES - 16'd1) begin
                        rd_timeout = 1'b1;
                        state_d    = S_WAIT_POLL;
                    end
                end
`endif
                default:     state_d = S_IDLE;
            endcase
        end
    end

    // Counters run only while the FSM stays in their wait state, so each entry starts from zero.
    always_ff @(posedge i2c_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            poll_cnt <= 16'd0;
            to_cnt   <= 16'd0;
        end else begin
            poll_cnt <= (state_q == S_WAIT_POLL && state_d == S_WAIT_POLL) ? poll_cnt + 16'd1 : 16'd0;
            to_cnt   <= (in_wait_end && state_d == state_q) ? to_cnt + 16'd1 : 16'd0;
        end
    end

    // Register address is loaded as a request is entered and held until the next one.
    always_ff @(posedge i2c_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rd_addr <= 8'h00;
        end else if (state_d == S_IDLE) begin
            rd_addr <= 8'h00;
        end else if (state_d == S_REQ) begin
            rd_addr <= FLAG_REG;
`ifdef GESTURE_WAVE_EN
        end else if (state_d == S_REQ2) begin
            rd_addr <= ADDR_FLAG2;
`endif
        end
    end

    // Capture the flag byte on completion; only the first register's byte is exposed.
    always_ff @(posedge i2c_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            gesture_raw <= 8'h00;
        end else if (active && state_q == S_WAIT_END && i2c_end) begin
            gesture_raw <= rd_data;
        end
    end

`ifdef GESTURE_WAVE_EN
    // Remember a wave hit for one cycle so its strobe lines up two cycles after i2c_end.
    always_ff @(posedge i2c_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wave_pend <= 1'b0;
        end else begin
            wave_pend <= active && (state_q == S_WAIT_END2) && i2c_end && rd_data[0];
        end
    end
`endif

    // Publish a decoded gesture with a single-cycle strobe; zero bytes leave the code untouched.
    always_ff @(posedge i2c_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            gesture_valid <= 1'b0;
            gesture_code  <= G_NONE;
        end else begin
            gesture_valid <= 1'b0;
            if (active && state_q == S_DECODE && dec_nz) begin
                gesture_valid <= 1'b1;
                gesture_code  <= dec_code;
            end
`ifdef GESTURE_WAVE_EN
            else if (active && wave_pend) begin
                gesture_valid <= 1'b1;
                gesture_code  <= G_WAVE;
            end
`endif
        end
    end

endmodule

// File: tb/tb_gesture_rd_ctrl.sv
// tb/tb_gesture_rd_ctrl.sv - scoreboard bench for gesture_rd_ctrl; honours GESTURE_WAVE_EN
module tb_gesture_rd_ctrl;

    localparam int POLL = 16;
    localparam int TMO  = 8;

    logic       i2c_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [2:0] step      = 3'd0;
    logic       i2c_end   = 1'b0;
    logic [7:0] rd_data   = 8'h00;
    logic       rd_start;
    logic [7:0] rd_addr;
    logic       gesture_valid;
    logic [3:0] gesture_code;
    logic [7:0] gesture_raw;
    logic       rd_timeout;

    gesture_rd_ctrl #(
        .POLL_CYCLES    (16'd16),
        .TIMEOUT_CYCLES (16'd8),
        .FLAG_REG       (8'h43)
    ) dut (
        .i2c_clk       (i2c_clk),
        .sys_rst_n     (sys_rst_n),
        .step          (step),
        .i2c_end       (i2c_end),
        .rd_data       (rd_data),
        .rd_start      (rd_start),
        .rd_addr       (rd_addr),
        .gesture_valid (gesture_valid),
        .gesture_code  (gesture_code),
        .gesture_raw   (gesture_raw),
        .rd_timeout    (rd_timeout)
    );

    always #5 i2c_clk = ~i2c_clk;

    int cyc = 0;
    always @(posedge i2c_clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] b;
        logic [3:0] c;
    } ev_t;

    ev_t q_req[$];
    ev_t q_gv[$];
    ev_t q_to[$];
    ev_t q_st[$];
    ev_t mon_e;

    int errors = 0;
    int checks = 0;

    logic [7:0] m_raw  = 8'h00;
    logic [3:0] m_code = 4'd0;
    int         wave_seen = 0;

    function automatic ev_t mk(input int c, input logic [7:0] b, input logic [3:0] k);
        ev_t e;
        e.cyc = c;
        e.b   = b;
        e.c   = k;
        return e;
    endfunction

    function automatic logic [3:0] lowest(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            if (b[i]) return 4'(i + 1);
        end
        return 4'd0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop an expectation whenever the DUT strobes, and flag expectations that were missed.
    always @(negedge i2c_clk) begin
        if (sys_rst_n) begin
            if (rd_start) begin
                if (q_req.size() == 0) check("unexpected_rd_start", 1, 0);
                else begin
                    mon_e = q_req.pop_front();
                    check("rd_start_cycle", cyc, mon_e.cyc);
                    check("rd_addr", rd_addr, mon_e.b);
                end
            end else if (q_req.size() > 0 && q_req[0].cyc < cyc) begin
                mon_e = q_req.pop_front();
                check("missed_rd_start", cyc, mon_e.cyc);
            end
            if (gesture_valid) begin
                if (q_gv.size() == 0) check("unexpected_gesture_valid", 1, 0);
                else begin
                    mon_e = q_gv.pop_front();
                    check("gesture_valid_cycle", cyc, mon_e.cyc);
                    check("gesture_code", gesture_code, mon_e.c);
                end
            end else if (q_gv.size() > 0 && q_gv[0].cyc < cyc) begin
                mon_e = q_gv.pop_front();
                check("missed_gesture_valid", cyc, mon_e.cyc);
            end
            if (rd_timeout) begin
                if (q_to.size() == 0) check("unexpected_rd_timeout", 1, 0);
                else begin
                    mon_e = q_to.pop_front();
                    check("rd_timeout_cycle", cyc, mon_e.cyc);
                end
            end else if (q_to.size() > 0 && q_to[0].cyc < cyc) begin
                mon_e = q_to.pop_front();
                check("missed_rd_timeout", cyc, mon_e.cyc);
            end
            while (q_st.size() > 0 && q_st[0].cyc <= cyc) begin
                mon_e = q_st.pop_front();
                check("gesture_raw_hold", gesture_raw, mon_e.b);
                check("gesture_code_hold", gesture_code, mon_e.c);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: cycle %0d exceeded time limit", cyc);
        $fatal(1);
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge i2c_clk);
            #1;
        end
    endtask

    task automatic pulse_end(input int at, input logic [7:0] d);
        wait_cyc(at);
        i2c_end = 1'b1;
        rd_data = d;
        wait_cyc(at + 1);
        i2c_end = 1'b0;
        rd_data = 8'($urandom);
    endtask

    task automatic set_step(input logic [2:0] v, output int first_req);
        step      = v;
        first_req = cyc + 1 + POLL;
        if (v == 3'd5) q_req.push_back(mk(first_req, 8'h43, 4'd0));
    endtask

    // One poll: the request at t is already expected; d in 1..TMO answers, anything else times out.
    task automatic do_poll(input int t, input int d, input logic [7:0] data, output int t_next);
        int e;
`ifdef GESTURE_WAVE_EN
        int         t2, d2, e2;
        logic [7:0] b2;
`endif
        if (d >= 1 && d <= TMO) begin
            e     = t + d;
            m_raw = data;
            if (data != 8'h00) begin
                m_code = lowest(data);
                q_gv.push_back(mk(e + 2, 8'h00, m_code));
            end
            q_st.push_back(mk(e + 3, m_raw, m_code));
            t_next = e + 2 + POLL;
`ifdef GESTURE_WAVE_EN
            if (data == 8'h00) begin
                t2 = e + 2;
                q_req.push_back(mk(t2, 8'h44, 4'd0));
                d2 = (wave_seen == 0) ? 3 : $urandom_range(1, TMO + 2);
                b2 = (wave_seen == 0) ? 8'h01 : 8'($urandom);
                wave_seen++;
                if (d2 <= TMO) begin
                    e2 = t2 + d2;
                    if (b2[0]) begin
                        m_code = 4'd9;
                        q_gv.push_back(mk(e2 + 2, 8'h00, 4'd9));
                    end
                    q_st.push_back(mk(e2 + 3, m_raw, m_code));
                    t_next = e2 + 1 + POLL;
                end else begin
                    q_to.push_back(mk(t2 + TMO, 8'h00, 4'd0));
                    t_next = t2 + TMO + 1 + POLL;
                end
                q_req.push_back(mk(t_next, 8'h43, 4'd0));
                pulse_end(e, data);
                if (d2 <= TMO) pulse_end(t2 + d2, b2);
                return;
            end
`endif
            q_req.push_back(mk(t_next, 8'h43, 4'd0));
            pulse_end(e, data);
        end else begin
            q_to.push_back(mk(t + TMO, 8'h00, 4'd0));
            q_st.push_back(mk(t + TMO + 1, m_raw, m_code));
            t_next = t + TMO + 1 + POLL;
            q_req.push_back(mk(t_next, 8'h43, 4'd0));
            pulse_end(t + TMO + 1 + $urandom_range(0, 3), 8'($urandom));
        end
    endtask

    initial begin
        int t;
        int d;
        logic [7:0] b;

        repeat (3) @(posedge i2c_clk);
        #1;
        check("reset_rd_start", rd_start, 0);
        check("reset_rd_addr", rd_addr, 0);
        check("reset_gesture_valid", gesture_valid, 0);
        check("reset_gesture_code", gesture_code, 0);
        check("reset_gesture_raw", gesture_raw, 0);
        check("reset_rd_timeout", rd_timeout, 0);
        sys_rst_n = 1'b1;
        @(posedge i2c_clk);
        #1;

        set_step(3'd5, t);
        do_poll(t, 3, 8'h04, t);
        do_poll(t, 2, 8'h90, t);
        do_poll(t, 5, 8'h00, t);
        do_poll(t, 0, 8'h00, t);
        do_poll(t, TMO, 8'h80, t);

        for (int i = 0; i < 20; i++) begin
            d = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TMO);
            b = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            do_poll(t, d, b, t);
        end

        wait_cyc(t + 2);
        step = 3'd4;
        wait_cyc(t + 4);
        check("rd_addr_idle", rd_addr, 0);
        q_st.push_back(mk(t + 8, m_raw, m_code));
        pulse_end(t + 6, 8'h01);
        wait_cyc(t + 9);
        set_step(3'd5, t);

        for (int i = 0; i < 6; i++) begin
            d = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, TMO);
            b = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            do_poll(t, d, b, t);
        end

        wait_cyc(t - 2);
        step = 3'd0;
        void'(q_req.pop_back());
        wait_cyc(t + 6);
        check("left_rd_start", q_req.size(), 0);
        check("left_gesture_valid", q_gv.size(), 0);
        check("left_rd_timeout", q_to.size(), 0);
        check("left_state_checks", q_st.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
